uart_cmd_sequencer: RTL and testbench

- Synthesizable host-side command engine for the UART ALU.
- Takes one command per handshake: an opcode plus up to MAX_OPERANDS_P operands. Serialises it as a framed byte stream into a UART transmitter's AXI-stream slave port.
- Collects a fixed-length response from the UART receiver's AXI-stream master port and presents it as one word, with timeout detection.
- Parametrised successor to the bench-only byte sender; allows on-chip or emulation-based self-test of the top-level ALU.

---
 rtl/uart_cmd_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_uart_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: host-side command engine for the UART ALU.
// Frames one command (opcode, 0x00, LEN16, operands) out over AXI-stream.
// It then gathers a fixed-length response from AXI-stream and presents it as one word.
// A timeout ends response collection early.
// Optional macro UART_SEQ_CHECKSUM_EN appends an XOR checksum byte to each frame.
// Ports:
//   clk, rst (async, active-low)
//   cmd_*  : command handshake (opcode, operand count, packed operands)
//   tx_*   : AXI-stream master toward the UART transmitter
//   rx_*   : AXI-stream slave from the UART receiver
//   rsp_*  : response word handshake, with a timeout qualifier
//   busy_o : high in any state other than idle
module uart_cmd_sequencer #(
    parameter int DATA_WIDTH_P     = 8,
    parameter int MAX_OPERANDS_P   = 4,
    parameter int OPERAND_W_P      = 32,
    parameter int RESP_BYTES_P     = 4,
    parameter int TIMEOUT_CYCLES_P = 1000000
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid_i,
    output logic                                   cmd_ready_o,
    input  logic [DATA_WIDTH_P-1:0]                cmd_opcode_i,
    input  logic [$clog2(MAX_OPERANDS_P+1)-1:0]    cmd_count_i,
    input  logic [MAX_OPERANDS_P*OPERAND_W_P-1:0] cmd_operands_i,
    output logic [DATA_WIDTH_P-1:0]                tx_tdata_o,
    output logic                                   tx_tvalid_o,
    input  logic                                   tx_tready_i,
    input  logic [DATA_WIDTH_P-1:0]                rx_tdata_i,
    input  logic                                   rx_tvalid_i,
    output logic                                   rx_tready_o,
    output logic                                   rsp_valid_o,
    input  logic                                   rsp_ready_i,
    output logic [RESP_BYTES_P*DATA_WIDTH_P-1:0]   rsp_data_o,
    output logic                                   rsp_timeout_o,
    output logic                                   busy_o
);

    localparam int DW = DATA_WIDTH_P;
    localparam int OB = OPERAND_W_P / DW;
    localparam int CW = $clog2(MAX_OPERANDS_P + 1);
    localparam int OW = MAX_OPERANDS_P * OPERAND_W_P;
    localparam int BW = $clog2(MAX_OPERANDS_P * OB + 4);
    localparam int RW = (RESP_BYTES_P > 1) ? $clog2(RESP_BYTES_P) : 1;
    localparam int TW = (TIMEOUT_CYCLES_P > 1) ? $clog2(TIMEOUT_CYCLES_P) : 1;
`ifdef UART_SEQ_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_OPND,
        S_CSUM,
        S_WAIT,
        S_OUT
    } state_t;

    // State entered once the last header/operand byte has gone out.
`ifdef UART_SEQ_CHECKSUM_EN
    localparam state_t DATA_DONE = S_CSUM;
`else
    localparam state_t DATA_DONE = S_WAIT;
`endif

    state_t state_q, state_d;

    logic [DW-1:0]              opcode_q;
    logic [OW-1:0]              opnd_q;
    logic [BW-1:0]              nbytes_q;
    logic [BW-1:0]              cnt_q;
    logic [15:0]                len_q;
    logic [DW-1:0]              csum_q;
    logic [RW-1:0]              rx_idx_q;
    logic [TW-1:0]              tmo_q;
    logic [RESP_BYTES_P*DW-1:0] rsp_q;
    logic                       tmo_flag_q;

    logic [CW-1:0] count_eff;
    logic [15:0]   len_d;
    logic [BW-1:0] nbytes_d;
    logic          cmd_fire;
    logic          tx_fire;
    logic          rx_fire;
    logic          hdr_last;
    logic          opnd_last;
    logic          rx_last;
    logic          tmo_hit;

    assign count_eff = (int'(cmd_count_i) > MAX_OPERANDS_P) ?
                       CW'(MAX_OPERANDS_P) : cmd_count_i;
    // LEN is deliberately truncated to 16 bits.
    assign len_d     = 16'(4 + CS + int'(count_eff) * OB);
    assign nbytes_d  = BW'(int'(count_eff) * OB);

    assign cmd_ready_o   = (state_q == S_IDLE);
    assign busy_o        = (state_q != S_IDLE);
    assign rx_tready_o   = (state_q != S_OUT);
    assign rsp_valid_o   = (state_q == S_OUT);
    assign rsp_data_o    = rsp_q;
    assign rsp_timeout_o = tmo_flag_q;

    assign cmd_fire  = cmd_valid_i && cmd_ready_o;
    assign tx_fire   = tx_tvalid_o && tx_tready_i;
    assign rx_fire   = rx_tvalid_i && rx_tready_o;
    assign hdr_last  = (cnt_q == BW'(3));
    assign opnd_last = (cnt_q == nbytes_q - BW'(1));
    assign rx_last   = (rx_idx_q == RW'(RESP_BYTES_P - 1));
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES_P - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_tvalid_o = 1'b0;
        tx_tdata_o  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_fire) state_d = S_HDR;
            end
            S_HDR: begin
                tx_tvalid_o = 1'b1;
                unique case (cnt_q[1:0])
                    2'd0:    tx_tdata_o = opcode_q;
                    2'd1:    tx_tdata_o = '0;
                    2'd2:    tx_tdata_o = len_q[7:0];
                    default: tx_tdata_o = len_q[15:8];
                endcase
                if (tx_tready_i && hdr_last)
                    state_d = (nbytes_q == '0) ? DATA_DONE : S_OPND;
            end
            S_OPND: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = opnd_q[DW-1:0];
                if (tx_tready_i && opnd_last) state_d = DATA_DONE;
            end
            S_CSUM: begin
                tx_tvalid_o = 1'b1;
                tx_tdata_o  = csum_q;
                if (tx_tready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rx_fire && rx_last) state_d = S_OUT;
                else if (tmo_hit)       state_d = S_OUT;
            end
            S_OUT: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opcode_q   <= '0;
            opnd_q     <= '0;
            nbytes_q   <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            csum_q     <= '0;
            rx_idx_q   <= '0;
            tmo_q      <= '0;
            rsp_q      <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                opcode_q   <= cmd_opcode_i;
                opnd_q     <= cmd_operands_i;
                nbytes_q   <= nbytes_d;
                len_q      <= len_d;
                cnt_q      <= '0;
                csum_q     <= '0;
                rx_idx_q   <= '0;
                tmo_q      <= '0;
                rsp_q      <= '0;
                tmo_flag_q <= 1'b0;
            end
            if (tx_fire) begin
                csum_q <= csum_q ^ tx_tdata_o;
                if (state_q == S_HDR) begin
                    cnt_q <= hdr_last ? '0 : cnt_q + BW'(1);
                end
                if (state_q == S_OPND) begin
                    cnt_q  <= cnt_q + BW'(1);
                    opnd_q <= opnd_q >> DW;
                end
            end
            if (state_q == S_WAIT) begin
                if (rx_fire) begin
                    rsp_q[int'(rx_idx_q)*DW +: DW] <= rx_tdata_i;
                    rx_idx_q <= rx_idx_q + RW'(1);
                    tmo_q    <= '0;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
                // A byte landing on the terminal count only rescues the
                // response when it is the final one.
                if (tmo_hit && !(rx_fire && rx_last)) tmo_flag_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed plus randomized bench for uart_cmd_sequencer.
// Expected frames and responses come from a byte-queue model of the protocol.
module tb_uart_cmd_sequencer;

    localparam int MAXO = 4;
    localparam int OW   = 32;
    localparam int RB   = 4;
    localparam int TO   = 100;
`ifdef UART_SEQ_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready_o;
    logic [7:0]   cmd_opcode = '0;
    logic [2:0]   cmd_count = '0;
    logic [127:0] cmd_operands = '0;
    logic [7:0]   tx_tdata_o;
    logic         tx_tvalid_o;
    logic         tx_tready = 1'b0;
    logic [7:0]   rx_tdata = '0;
    logic         rx_tvalid = 1'b0;
    logic         rx_tready_o;
    logic         rsp_valid_o;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_data_o;
    logic         rsp_timeout_o;
    logic         busy_o;

    int checks = 0;
    int errors = 0;
    byte unsigned exp_q[$];
    byte unsigned got_q[$];
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data = '0;
    logic         rsp_seen = 1'b0;
    logic [31:0]  last_rsp = '0;

    uart_cmd_sequencer #(
        .DATA_WIDTH_P    (8),
        .MAX_OPERANDS_P  (MAXO),
        .OPERAND_W_P     (OW),
        .RESP_BYTES_P    (RB),
        .TIMEOUT_CYCLES_P(TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_opcode_i  (cmd_opcode),
        .cmd_count_i   (cmd_count),
        .cmd_operands_i(cmd_operands),
        .tx_tdata_o    (tx_tdata_o),
        .tx_tvalid_o   (tx_tvalid_o),
        .tx_tready_i   (tx_tready),
        .rx_tdata_i    (rx_tdata),
        .rx_tvalid_i   (rx_tvalid),
        .rx_tready_o   (rx_tready_o),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data_o),
        .rsp_timeout_o (rsp_timeout_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe on the falling edge, return just after the rise.
    task automatic step();
        @(negedge clk);
        if (prev_stall) begin
            check("tx_hold_valid", tx_tvalid_o, 1);
            check("tx_hold_data", tx_tdata_o, prev_data);
        end
        prev_stall = tx_tvalid_o && !tx_tready;
        prev_data  = tx_tdata_o;
        if (tx_tvalid_o && tx_tready) got_q.push_back(tx_tdata_o);
        rsp_seen = rsp_valid_o;
        @(posedge clk);
        #1;
    endtask

    function automatic void build_frame(input byte unsigned op, input int cnt,
                                        input logic [127:0] ops);
        int n;
        int len;
        byte unsigned x;
        n   = (cnt > MAXO) ? MAXO : cnt;
        len = 4 + n * (OW / 8) + CS;
        exp_q.delete();
        exp_q.push_back(op);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(len % 256));
        exp_q.push_back(8'((len / 256) % 256));
        for (int k = 0; k < n; k++)
            for (int b = 0; b < OW / 8; b++)
                exp_q.push_back(8'(ops >> (k * OW + b * 8)));
        if (CS == 1) begin
            x = 0;
            foreach (exp_q[i]) x = x ^ exp_q[i];
            exp_q.push_back(x);
        end
    endfunction

    task automatic run_cmd(input byte unsigned op, input int cnt,
                           input logic [127:0] ops, input int mode,
                           input int nrsp, input bit stray,
                           input logic [31:0] rsp_word, input int hold);
        int guard;
        int ncyc;
        int lat;
        int gap;
        logic [31:0] exp_rsp;
        build_frame(op, cnt, ops);
        got_q.delete();
        guard = 0;
        while (!cmd_ready_o && guard < 50) begin
            step();
            guard++;
        end
        check("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid    = 1'b1;
        cmd_opcode   = op;
        cmd_count    = 3'(cnt);
        cmd_operands = ops;
        tx_tready    = 1'b0;
        step();
        cmd_valid = 1'b0;
        check("cmd_ready_drop", cmd_ready_o, 0);
        check("first_valid", tx_tvalid_o, 1);
        check("busy", busy_o, 1);
        ncyc = 0;
        while (got_q.size() < exp_q.size() && ncyc < 400) begin
            case (mode)
                0:       tx_tready = 1'b1;
                1:       tx_tready = (ncyc % 2 == 0);
                default: tx_tready = 1'($urandom_range(0, 1));
            endcase
            if (stray && ncyc == 0) begin
                check("stray_ready", rx_tready_o, 1);
                rx_tvalid = 1'b1;
                rx_tdata  = 8'hEE;
            end else begin
                rx_tvalid = 1'b0;
            end
            step();
            ncyc++;
        end
        tx_tready = 1'b0;
        rx_tvalid = 1'b0;
        check("frame_len", got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size())
                check($sformatf("frame_byte%0d", i), got_q[i], exp_q[i]);
        if (mode == 0) check("back_to_back", ncyc, exp_q.size());
        check("tx_idle_after", tx_tvalid_o, 0);
        exp_rsp = '0;
        for (int i = 0; i < nrsp; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) step();
            check("rx_ready_wait", rx_tready_o, 1);
            rx_tvalid = 1'b1;
            rx_tdata  = rsp_word[i*8 +: 8];
            exp_rsp[i*8 +: 8] = rsp_word[i*8 +: 8];
            step();
            rx_tvalid = 1'b0;
        end
        lat = 0;
        step();
        while (!rsp_seen && lat < TO + 10) begin
            lat++;
            step();
        end
        check("rsp_latency", lat, (nrsp >= RB) ? 0 : TO);
        check("rsp_valid", rsp_valid_o, 1);
        check("rsp_data", rsp_data_o, exp_rsp);
        check("rsp_timeout", rsp_timeout_o, (nrsp < RB) ? 1 : 0);
        check("rx_ready_out", rx_tready_o, 0);
        last_rsp = rsp_data_o;
        repeat (hold) begin
            step();
            check("rsp_hold_valid", rsp_valid_o, 1);
            check("rsp_hold_data", rsp_data_o, exp_rsp);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_released", rsp_valid_o, 0);
        check("cmd_ready_back", cmd_ready_o, 1);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        int guard;
        logic [127:0] ops;
        rst = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_rx_ready", rx_tready_o, 1);
        check("rst_tx_valid", tx_tvalid_o, 0);
        check("rst_tx_data", tx_tdata_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_data", rsp_data_o, 0);
        check("rst_timeout", rsp_timeout_o, 0);
        check("rst_busy", busy_o, 0);
        rst = 1'b1;
        step();

        ops = {64'd0, 32'h5, 32'h3};
        run_cmd(8'h8A, 2, ops, 0, 4, 1'b0, 32'h00000008, 2);
        check("plan_len_lo", got_q[2], 8'h0C + CS);
        check("plan_op1_lsb", got_q[8], 8'h05);
        check("plan_rsp_word", last_rsp, 32'h00000008);

        run_cmd(8'h8A, 2, ops, 1, 4, 1'b0, 32'h00000008, 0);

        run_cmd(8'h11, 1, {96'd0, 32'hDEADBEEF}, 0, 2, 1'b0,
                32'h0000BBAA, 1);
        check("plan_timeout_data", last_rsp, 32'h0000BBAA);

        ops = {32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
        run_cmd(8'h42, 7, ops, 0, 4, 1'b1, 32'h12345678, 0);
        check("plan_clamp_len", got_q[2], 8'h14 + CS);
        check("plan_clamp_size", got_q.size(), 20 + CS);

        ops = {64'd0, 32'h0BADF00D, 32'hCAFEF00D};
        build_frame(8'h33, 2, ops);
        got_q.delete();
        cmd_valid    = 1'b1;
        cmd_opcode   = 8'h33;
        cmd_count    = 3'd2;
        cmd_operands = ops;
        step();
        cmd_valid = 1'b0;
        tx_tready = 1'b1;
        guard = 0;
        while (got_q.size() < 6 && guard < 50) begin
            step();
            guard++;
        end
        check("mid_opnd_reached", got_q.size(), 6);
        #2;
        rst = 1'b0;
        #1;
        check("async_tx_valid", tx_tvalid_o, 0);
        check("async_cmd_ready", cmd_ready_o, 1);
        check("async_busy", busy_o, 0);
        tx_tready  = 1'b0;
        prev_stall = 1'b0;
        step();
        rst = 1'b1;
        step();
        run_cmd(8'h33, 2, ops, 0, 4, 1'b0, 32'hA5A55A5A, 0);

        run_cmd(8'h07, 0, '0, 2, 4, 1'b0, 32'h01020304, 1);

        for (int t = 0; t < 20; t++) begin
            int nr;
            ops = {$urandom, $urandom, $urandom, $urandom};
            nr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4;
            run_cmd(8'($urandom), int'($urandom_range(0, 7)), ops,
                    int'($urandom_range(0, 2)), nr,
                    1'($urandom_range(0, 1)), $urandom,
                    int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
